// File: rtl/btn_dir_ctrl_pkg.sv
// Shared types for the pushbutton direction controller: arbiter state encoding,
// direction codes and the default debounce length.
package btn_dir_ctrl_pkg;

  localparam int unsigned DebounceCyclesDefault = 500000;

  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StPend = 3'b010,
    StHold = 3'b100
  } arb_state_e;

  typedef enum logic [1:0] {
    DirU = 2'd0,
    DirD = 2'd1,
    DirL = 2'd2,
    DirR = 2'd3
  } dir_e;

  // Fixed priority U > D > L > R over a {U,D,L,R} level vector.
  function automatic dir_e prio_dir(input logic [3:0] lvl);
    if (lvl[3]) begin
      return DirU;
    end else if (lvl[2]) begin
      return DirD;
    end else if (lvl[1]) begin
      return DirL;
    end
    return DirR;
  endfunction

endpackage

// File: rtl/btn_dir_ctrl_debounce.sv
// Two-flop synchronizer followed by a saturating stability counter for one
// raw pushbutton.
module btn_debounce #(
  parameter int unsigned DebounceCycles = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic stable_o
);

  localparam int unsigned CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Counter only advances while the synced level disagrees; it tops out at
  // CntMax, where the level is accepted and the count restarts.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/btn_dir_ctrl.sv
// Debounces four direction buttons and issues at most one registered move pulse
// per press-release cycle, held until the game FSM signals ready.
module btn_dir_ctrl
  import btn_dir_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic       ready,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       dir_pending,
  output logic [3:0] stable
);

  logic [3:0] stable_w;
  logic [3:0] stable_prev_q;
  arb_state_e state_q, state_d;
  dir_e       dir_q, dir_d;
  logic [3:0] pulse_q, pulse_d;
  logic       pending_q, pending_d;

  btn_debounce #(.DebounceCycles(DEBOUNCE_CYCLES)) u_deb_u (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .btn_i   (BtnU),
    .stable_o(stable_w[3])
  );

  btn_debounce #(.DebounceCycles(DEBOUNCE_CYCLES)) u_deb_d (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .btn_i   (BtnD),
    .stable_o(stable_w[2])
  );

  btn_debounce #(.DebounceCycles(DEBOUNCE_CYCLES)) u_deb_l (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .btn_i   (BtnL),
    .stable_o(stable_w[1])
  );

  btn_debounce #(.DebounceCycles(DEBOUNCE_CYCLES)) u_deb_r (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .btn_i   (BtnR),
    .stable_o(stable_w[0])
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= StIdle;
      dir_q         <= DirU;
      stable_prev_q <= 4'b0000;
      pulse_q       <= 4'b0000;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      stable_prev_q <= stable_w;
      pulse_q       <= pulse_d;
      pending_q     <= pending_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    unique case (state_q)
      StIdle: begin
        // Accept only a press from the all-released condition.
        if ((stable_prev_q == 4'b0000) && (stable_w != 4'b0000)) begin
          dir_d   = prio_dir(stable_w);
          state_d = StPend;
        end
      end
      StPend: begin
        if (ready) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (stable_w == 4'b0000) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pulse_d   = 4'b0000;
    pending_d = (state_d == StPend);
    if ((state_q == StPend) && ready) begin
      pulse_d = 4'b1000 >> dir_q;
    end
  end

  assign up          = pulse_q[3];
  assign down        = pulse_q[2];
  assign left        = pulse_q[1];
  assign right       = pulse_q[0];
  assign dir_pending = pending_q;
  assign stable      = stable_w;

endmodule

// File: tb/tb_btn_dir_ctrl.sv
// Self-checking bench for btn_dir_ctrl with a short debounce; expected move
// pulses are queued at stimulus time and retired by a pulse monitor.
module tb_btn_dir_ctrl;

  localparam int unsigned Deb = 4;
  localparam logic [1:0] CodeU = 2'd0;
  localparam logic [1:0] CodeD = 2'd1;
  localparam logic [1:0] CodeL = 2'd2;
  localparam logic [1:0] CodeR = 2'd3;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       BtnU, BtnD, BtnL, BtnR, ready;
  logic       up, down, left, right, dir_pending;
  logic [3:0] stable;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int p;

  typedef struct {
    logic [1:0] dir;
    int         cyc;
  } exp_t;
  exp_t sb_q[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  btn_dir_ctrl #(.DEBOUNCE_CYCLES(Deb)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .BtnU       (BtnU),
    .BtnD       (BtnD),
    .BtnL       (BtnL),
    .BtnR       (BtnR),
    .ready      (ready),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .dir_pending(dir_pending),
    .stable     (stable)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  function automatic logic [1:0] code_of(input logic [3:0] pv);
    case (pv)
      4'b1000: return CodeU;
      4'b0100: return CodeD;
      4'b0010: return CodeL;
      default: return CodeR;
    endcase
  endfunction

  // Every pulse must match the oldest queued expectation.
  always @(negedge Clk) begin : mon
    logic [3:0] pv;
    exp_t       e;
    pv = {up, down, left, right};
    if (pv != 4'b0000) begin
      check("pulse_onehot", $countones(pv), 1);
      if (sb_q.size() == 0) begin
        check("spurious_pulse", {28'd0, pv}, 0);
      end else begin
        e = sb_q.pop_front();
        check("pulse_dir", {30'd0, code_of(pv)}, {30'd0, e.dir});
        if (e.cyc >= 0) check("pulse_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 20000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 1'b0;
    BtnU = 1'b0; BtnD = 1'b0; BtnL = 1'b0; BtnR = 1'b0;
    ready = 1'b0;
    #1;
    check("rst_stable", {28'd0, stable}, 0);
    check("rst_pulses", {28'd0, up, down, left, right}, 0);
    check("rst_pending", {31'd0, dir_pending}, 0);
    tick(3);
    Reset_n = 1'b1;
    tick(5);
    check("idle_stable", {28'd0, stable}, 0);
    check("idle_pending", {31'd0, dir_pending}, 0);

    // Single U press: stable after 6 cycles, pulse 2 later.
    ready = 1'b1;
    BtnU = 1'b1;
    p = cyc;
    sb_q.push_back('{dir: CodeU, cyc: p + 8});
    while (cyc != p + 5) @(negedge Clk);
    check("u_stable_pre", {31'd0, stable[3]}, 0);
    @(negedge Clk);
    check("u_stable_rise", {28'd0, stable}, 4'b1000);
    tick(14);
    BtnU = 1'b0;
    tick(15);
    check("u_drain", sb_q.size(), 0);
    check("u_released", {28'd0, stable}, 0);

    // Bouncing L never settles.
    for (int i = 0; i < 15; i++) begin
      BtnL = ~BtnL;
      tick(2);
      check("l_bounce_stable", {31'd0, stable[1]}, 0);
    end
    BtnL = 1'b0;
    tick(15);
    check("l_bounce_final", {31'd0, stable[1]}, 0);
    check("l_bounce_drain", sb_q.size(), 0);

    // D and R together: D wins, R ignored until full release.
    BtnD = 1'b1;
    BtnR = 1'b1;
    p = cyc;
    sb_q.push_back('{dir: CodeD, cyc: p + 8});
    tick(7);
    check("dr_stable", {28'd0, stable}, 4'b0101);
    tick(8);
    BtnD = 1'b0;
    tick(20);
    check("dr_r_held", {28'd0, stable}, 4'b0001);
    BtnR = 1'b0;
    tick(15);
    check("dr_drain", sb_q.size(), 0);
    BtnR = 1'b1;
    p = cyc;
    sb_q.push_back('{dir: CodeR, cyc: p + 8});
    tick(12);
    BtnR = 1'b0;
    tick(15);
    check("r_again_drain", sb_q.size(), 0);

    // Press and release R while not ready: move stays pending.
    ready = 1'b0;
    BtnR = 1'b1;
    tick(10);
    BtnR = 1'b0;
    tick(15);
    check("pend_hold", {31'd0, dir_pending}, 1);
    check("pend_released", {28'd0, stable}, 0);
    p = cyc;
    sb_q.push_back('{dir: CodeR, cyc: p + 1});
    ready = 1'b1;
    @(negedge Clk);
    check("pend_before_edge", {31'd0, dir_pending}, 1);
    @(negedge Clk);
    check("pend_clear", {31'd0, dir_pending}, 0);
    tick(5);
    check("pend_drain", sb_q.size(), 0);

    // Reset while pending drops the move.
    ready = 1'b0;
    BtnU = 1'b1;
    for (int i = 0; i < 20 && !dir_pending; i++) tick(1);
    check("rp_pending", {31'd0, dir_pending}, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("rp_outputs", {23'd0, up, down, left, right, dir_pending, stable}, 0);
    BtnU = 1'b0;
    ready = 1'b1;
    tick(2);
    Reset_n = 1'b1;
    tick(50);
    check("rp_drain", sb_q.size(), 0);
    check("rp_no_pending", {31'd0, dir_pending}, 0);

    // Button held across reset debounces anew and yields one pulse.
    ready = 1'b0;
    BtnL = 1'b1;
    tick(10);
    check("hr_pending", {31'd0, dir_pending}, 1);
    Reset_n = 1'b0;
    ready = 1'b1;
    tick(2);
    Reset_n = 1'b1;
    p = cyc;
    sb_q.push_back('{dir: CodeL, cyc: p + 8});
    tick(20);
    BtnL = 1'b0;
    tick(15);
    check("hr_drain", sb_q.size(), 0);

    // Long U hold with ready toggling: one pulse only.
    BtnU = 1'b1;
    sb_q.push_back('{dir: CodeU, cyc: -1});
    for (int i = 0; i < 100; i++) begin
      ready = ~ready;
      tick(1);
    end
    BtnU = 1'b0;
    ready = 1'b1;
    tick(15);
    check("tog_drain", sb_q.size(), 0);
    check("tog_pending", {31'd0, dir_pending}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_dir_ctrl.md
BTN_DIR_CTRL -- requirements
Module: btn_dir_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000 (5 ms at 100 MHz), the consecutive stable cycles needed to accept a button level change; legal range 2..2^20.
REQ-002 SHALL have port Clk, input, 1, the single system clock; all logic is on the rising edge.
REQ-003 SHALL have port Reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have ports BtnU, BtnD, BtnL, BtnR, input, 1 each, raw asynchronous pushbuttons, active-high.
REQ-005 SHALL have port ready, input, 1, high when the game FSM is in WAIT and can accept a move.
REQ-006 SHALL have ports up, down, left, right, output, 1 each, one-cycle move pulses to the game FSM.
REQ-007 SHALL have port dir_pending, output, 1, high while a move is latched but not yet issued.
REQ-008 SHALL have port stable, output, 4, the debounced levels {U,D,L,R}, MSB = U.

Function
REQ-009 SHALL pass each raw button through a 2-flop synchronizer before any other use.
REQ-010 SHALL debounce each button with its own counter: count while synced != stable, clear to 0 when equal; when count reaches DEBOUNCE_CYCLES-1 and synced still differs, stable takes synced and the counter clears.
REQ-011 SHALL size each counter as clog2(DEBOUNCE_CYCLES) bits, saturating and never wrapping.
REQ-012 SHALL run an arbiter FSM with states IDLE, PEND, HOLD.
REQ-013 IDLE: when any stable bit rises and no other was already high, SHALL latch one direction with fixed priority U>D>L>R and go to PEND.
REQ-014 PEND: dir_pending=1; in the first cycle with ready=1, SHALL assert exactly the latched output for that one cycle, then go to HOLD.
REQ-015 PEND: if all stable bits go low before ready, SHALL still issue the latched move when ready rises (the press is never lost).
REQ-016 HOLD: SHALL issue no pulses and return to IDLE only after all four stable bits have been 0 for one cycle; holding a button never auto-repeats.
REQ-017 SHALL never assert more than one of up/down/left/right in a cycle, and never more than one pulse per press-release cycle.
REQ-018 With simultaneous debounced rises in the same cycle in IDLE, SHALL take the highest priority direction only; the others are ignored until full release.
REQ-019 The latency from a stable rise (ready=1) to the pulse SHALL be exactly 2 cycles: 1 to latch into PEND, 1 to output.
REQ-020 All outputs SHALL be registered.

Reset
REQ-021 Reset_n=0 SHALL clear synchronizers, counters, stable=4'b0000, latched direction, and up/down/left/right/dir_pending=0; the FSM goes to IDLE.
REQ-022 Reset mid-PEND or mid-HOLD SHALL drop the pending move with no pulse after release; a button held across reset SHALL debounce anew and produce one pulse.

Structure
REQ-023 A shared package SHALL hold the arbiter state encoding (one-hot, 3 bits), the 2-bit direction code (U=0,D=1,L=2,R=3) and the default DEBOUNCE_CYCLES.
REQ-024 The synchronizer plus debounce counter SHALL be one sub-module, btn_debounce, instantiated four times.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 Press BtnU for 20 cycles with ready=1 -> stable[3] rises 6 cycles after the press (2 sync + 4 count), up pulses once 2 cycles later, no further pulses.
REQ-026 Toggle BtnL every 2 cycles for 30 cycles, then release -> stable[1] stays 0, no pulse.
REQ-027 BtnD and BtnR rise in the same cycle, ready=1 -> only down pulses once; release BtnD while holding BtnR -> no right pulse until both are released and BtnR is pressed again.
REQ-028 ready=0, press and release BtnR -> dir_pending=1 persists; set ready=1 -> right pulses the next cycle, dir_pending clears.
REQ-029 Reset_n pulsed low while in PEND -> all outputs 0 immediately; after release of reset with no buttons pressed, no pulse over 50 cycles.
REQ-030 Hold BtnU for 100 cycles with ready toggling -> exactly one up pulse in total.
